// File: rtl/acq_stream_tx.sv
// AXI4-Stream transmitter: packetizes free-running acquisition samples into
// fixed-length packets, buffering them in a FIFO that ends in the output register.
module acq_stream_tx #(
    parameter int DW = 16,
    parameter int FD = 4,
    parameter int LW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ctl_start,
    input  logic            ctl_stop,
    input  logic [LW-1:0]   cfg_len,
    input  logic [LW-1:0]   cfg_num,
    input  logic [DW-1:0]   sti_dat,
    input  logic            sti_vld,
    output logic [DW-1:0]   stx_tdata,
    output logic [DW/8-1:0] stx_tkeep,
    output logic            stx_tlast,
    output logic            stx_tvalid,
    input  logic            stx_tready,
    output logic            sts_run,
    output logic            sts_ovf,
    output logic [15:0]     sts_ovf_cnt,
    output logic [LW-1:0]   sts_pkt_cnt
);
    localparam int DEPTH = 2 ** FD;
    localparam int CW    = FD + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state;
    logic [LW-1:0] len_q, num_q, in_cnt, in_pkt, out_cnt;
    logic          stop_req;
    logic [DW-1:0] mem [DEPTH];
    logic [FD-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] mem_cnt, occ;
    logic          full;

    logic          hs, in_run, stop_now, wr_en, drop, ld_en;
    logic [LW-1:0] out_cnt_nxt, beat_idx, in_pkt_nxt;
    logic [CW-1:0] mem_cnt_nxt, occ_nxt;

    // occ counts memory plus output register, so full covers the whole 2**FD capacity.
    always_comb begin
        hs          = stx_tvalid & stx_tready;
        in_run      = (state == S_RUN);
        stop_now    = in_run && (stop_req || ctl_stop) && (in_cnt == '0);
        wr_en       = in_run && sti_vld && !full && !stop_now;
        drop        = in_run && sti_vld && full && !stop_now;
        ld_en       = (mem_cnt != '0) && (!stx_tvalid || stx_tready);
        out_cnt_nxt = (out_cnt == len_q) ? '0 : out_cnt + 1'b1;
        beat_idx    = hs ? out_cnt_nxt : out_cnt;
        in_pkt_nxt  = in_pkt + 1'b1;
        mem_cnt_nxt = mem_cnt + CW'(wr_en) - CW'(ld_en);
        occ_nxt     = occ + CW'(wr_en) - CW'(hs);
    end

    assign stx_tkeep = '1;
    assign sts_run   = (state != S_IDLE);

    // NOTE: the sample memory has no reset; validity is tracked by the pointers
    // and counts, and a reset port here would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sti_dat;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather
    // than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            in_cnt      <= '0;
            in_pkt      <= '0;
            out_cnt     <= '0;
            stop_req    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            occ         <= '0;
            full        <= 1'b0;
            stx_tdata   <= '0;
            stx_tlast   <= 1'b0;
            stx_tvalid  <= 1'b0;
            sts_ovf     <= 1'b0;
            sts_ovf_cnt <= '0;
            sts_pkt_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (ld_en) begin
                rd_ptr     <= rd_ptr + 1'b1;
                stx_tdata  <= mem[rd_ptr];
                stx_tlast  <= (beat_idx == len_q);
                stx_tvalid <= 1'b1;
            end else if (hs) begin
                stx_tvalid <= 1'b0;
            end
            mem_cnt <= mem_cnt_nxt;
            occ     <= occ_nxt;
            full    <= (occ_nxt == CW'(DEPTH));

            if (hs) begin
                out_cnt <= out_cnt_nxt;
                if (stx_tlast) sts_pkt_cnt <= sts_pkt_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (ctl_start) begin
                        state       <= S_RUN;
                        len_q       <= cfg_len;
                        num_q       <= cfg_num;
                        in_cnt      <= '0;
                        in_pkt      <= '0;
                        out_cnt     <= '0;
                        stop_req    <= 1'b0;
                        sts_pkt_cnt <= '0;
                        sts_ovf     <= 1'b0;
                        sts_ovf_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (ctl_stop) stop_req <= 1'b1;
                    if (drop) begin
                        sts_ovf <= 1'b1;
                        if (sts_ovf_cnt != '1) sts_ovf_cnt <= sts_ovf_cnt + 16'd1;
                    end
                    // Leaving on the final write keeps the next sample out of a new packet.
                    if (stop_now) begin
                        state <= S_DRAIN;
                    end else if (wr_en) begin
                        if (in_cnt == len_q) begin
                            in_cnt <= '0;
                            in_pkt <= in_pkt_nxt;
                            if (num_q != '0 && in_pkt_nxt == num_q) state <= S_DRAIN;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_cnt == '0 && !stx_tvalid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
